alu_result_register: RTL and testbench
======================================

Name: alu_result_register

Overview:
- Downstream stage of the 8-bit lab ALU.
- Captures the ALU's 8-bit result into a register on a rising edge of a load strobe.
- Presents the stored value to LEDR/HEX drivers and feeds its low nibble back to the ALU as operand B, which turns the ALU into an accumulator.
- A small FSM tracks empty/loaded/frozen status; an optional 4-entry history buffer records past results for display scrolling.

Parameters:
- DATA_W, 8, width of ALU result and stored register.
- FB_W, 4, width of the operand-B feedback slice (low bits of the register).
- HIST_DEPTH, 4, history entries; must be a power of two.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_result  input  DATA_W  current combinational ALU output.
- alu_func  input  3  ALU function select in force when alu_result is sampled.
- load  input  1  level load request, already debounced and inverted to active-high.
- clear  input  1  synchronous clear of the stored value.
- freeze  input  1  while high, load edges are ignored.
- reg_out  output  DATA_W  stored result.
- b_feedback  output  FB_W  reg_out[FB_W-1:0], to the ALU B operand.
- valid  output  1  high when reg_out holds a captured result.
- zero  output  1  high when valid and reg_out == 0.
- hist_sel  input  2  history read index, 0 = newest (feature only).
- hist_data  output  DATA_W+3  {func, result} of the selected entry (feature only).
- hist_count  output  3  number of valid history entries, 0..4 (feature only).

Behaviour:
- Reset values:
  - reg_out=0, valid=0, zero=0, state=EMPTY, load_q=0.
  - hist_count=0, write pointer=0, all history entries=0.
- Edge detect: load_q registers load every cycle; load_rise = load & ~load_q.
- Load:
  - A load held high produces exactly one capture.
  - reg_out takes the alu_result value present in the same cycle load_rise is seen; new value is visible after 1 clock.
- FSM states: EMPTY, LOADED, FROZEN.
  - EMPTY: valid=0. load_rise & ~freeze -> capture, go LOADED. freeze -> FROZEN.
  - LOADED: valid=1. load_rise & ~freeze -> capture, stay LOADED. freeze -> FROZEN.
  - FROZEN: no captures. freeze low -> LOADED if a capture has occurred since the last reset/clear, else EMPTY.
- Clear:
  - Wins over load in the same cycle.
  - Sets reg_out=0, valid=0, state=EMPTY, and the history write pointer and count to 0.
  - Works in any state, including FROZEN. A clear held while freeze is high lands in FROZEN on the first cycle freeze is high with clear low.
- Load while frozen:
  - The rise is dropped, not queued.
  - Releasing freeze while load is still high causes no capture, because load_q is already high.
- Feedback: b_feedback is purely combinational from reg_out. No combinational path from alu_result to b_feedback, so the ALU/register loop is broken by the register.
- zero: combinational, equals valid & (reg_out==0).
- Width rule: no arithmetic here; alu_result is stored bit-exact with no truncation or extension.
- Reset mid-capture: reset wins over load and clear; state returns to EMPTY.

Optional Feature:
- Macro: ALU_RESULT_HISTORY_EN.
- With the macro defined:
  - Each capture also writes {alu_func, alu_result} at the write pointer; the pointer wraps modulo HIST_DEPTH.
  - hist_count increments and saturates at 4.
  - hist_data is the entry at (wptr-1-hist_sel) mod 4, returned combinationally.
  - If hist_sel >= hist_count, hist_data=0.
- Without the macro: no history storage; hist_data ties to 0 and hist_count ties to 0. Ports remain for a fixed interface.

Decomposition:
- Shared package holds:
  - FSM state typedef (EMPTY=2'd0, LOADED=2'd1, FROZEN=2'd2).
  - DATA_W and FB_W constants.
  - ALU function-code constants 3'd0..3'd5 (inc, add, plus, xor/or, reduce-or, concat).
- One sub-module is natural: alu_history_buf, the 4-entry circular buffer with write pointer, count and read mux. It is instantiated only under ALU_RESULT_HISTORY_EN.

Test Plan:
- Capture and feedback: reset; alu_result=8'h3C; pulse load for 1 cycle -> next cycle reg_out=8'h3C, b_feedback=4'hC, valid=1, zero=0.
- Single capture per press: hold load high 5 cycles while alu_result steps 8'h01..8'h05 -> reg_out=8'h01 only.
- Freeze drops loads:
  - Capture 8'h10; freeze=1; rise on load with alu_result=8'h20 -> reg_out stays 8'h10.
  - freeze=0 -> state LOADED, valid=1.
- Clear beats load: clear=1 and load_rise in the same cycle with alu_result=8'hFF -> reg_out=0, valid=0, zero=0.
- History wrap (feature on):
  - Capture 8'h01..8'h05 with alu_func=3'd1.
  - hist_count=4.
  - hist_sel=0 -> {3'd1,8'h05}; hist_sel=3 -> {3'd1,8'h02}.
  - After clear, hist_count=0 and hist_data=0.
- Reset mid-operation: in LOADED with reg_out=8'hA5, assert reset together with load -> reg_out=0, valid=0, state EMPTY, hist_count=0.

Source files
------------

// File: rtl/alu_result_register_pkg.sv
// Shared types and constants for the ALU result register slice.
// Included by alu_result_register and alu_history_buf.
package alu_result_register_pkg;

    localparam int DATA_W     = 8;
    localparam int FB_W       = 4;
    localparam int HIST_DEPTH = 4;
    localparam int FUNC_W     = 3;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam logic [2:0] FUNC_INC       = 3'd0;
    localparam logic [2:0] FUNC_ADD       = 3'd1;
    localparam logic [2:0] FUNC_PLUS      = 3'd2;
    localparam logic [2:0] FUNC_XOR_OR    = 3'd3;
    localparam logic [2:0] FUNC_REDUCE_OR = 3'd4;
    localparam logic [2:0] FUNC_CONCAT    = 3'd5;

endpackage

// File: rtl/alu_history_buf.sv
// Circular buffer of past {func, result} captures with newest-first read mux.
// Used only when ALU_RESULT_HISTORY_EN is defined.
module alu_history_buf #(
    parameter int DEPTH  = 4,
    parameter int ENTRY_W = 11,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_sel,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [PTR_W:0]     count
);
    import alu_result_register_pkg::*;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W-1:0]   w_rd_idx;

    // Entry storage, write pointer and saturating fill count
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            // Entries are left in place; the zero count hides them from reads.
            r_wptr  <= '0;
            r_count <= '0;
        end else if (wr_en) begin
            r_mem[r_wptr] <= wr_data;
            r_wptr        <= r_wptr + PTR_W'(1);
            if (r_count != (PTR_W+1)'(DEPTH)) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end
        end
    end

    // Newest-first read; slots beyond the fill count read as zero
    always_comb begin
        w_rd_idx = r_wptr - PTR_W'(1) - rd_sel;
        if ({1'b0, rd_sel} < r_count) begin
            rd_data = r_mem[w_rd_idx];
        end else begin
            rd_data = '0;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/alu_result_register.sv
// Result register behind the lab ALU: edge-triggered capture, freeze/clear FSM,
// operand-B feedback. Optional history buffer enabled by ALU_RESULT_HISTORY_EN.
module alu_result_register #(
    parameter int DATA_W     = alu_result_register_pkg::DATA_W,
    parameter int FB_W       = alu_result_register_pkg::FB_W,
    parameter int HIST_DEPTH = alu_result_register_pkg::HIST_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_func,
    input  logic              load,
    input  logic              clear,
    input  logic              freeze,
    output logic [DATA_W-1:0] reg_out,
    output logic [FB_W-1:0]   b_feedback,
    output logic              valid,
    output logic              zero,
    input  logic [1:0]        hist_sel,
    output logic [DATA_W+2:0] hist_data,
    output logic [2:0]        hist_count
);
    import alu_result_register_pkg::*;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_load_q;
    logic [DATA_W-1:0] r_reg;
    logic              r_valid;
    logic [DATA_W-1:0] w_reg_next;
    logic              w_valid_next;
    logic              w_load_rise;
    logic              w_capture;

    assign w_load_rise = load & ~r_load_q;

    // Edge-detect flop, FSM state and stored result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_q <= 1'b0;
            r_state  <= ST_EMPTY;
            r_reg    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_load_q <= load;
            r_state  <= w_state_next;
            r_reg    <= w_reg_next;
            r_valid  <= w_valid_next;
        end
    end

    // Next state and capture decision; clear overrides everything but reset
    always_comb begin
        w_state_next = r_state;
        w_reg_next   = r_reg;
        w_valid_next = r_valid;
        w_capture    = 1'b0;
        if (clear) begin
            w_state_next = ST_EMPTY;
            w_reg_next   = '0;
            w_valid_next = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_LOADED: begin
                    if (w_load_rise && !freeze) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_LOADED;
                    end else if (freeze) begin
                        w_state_next = ST_FROZEN;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_FROZEN: begin
                    // r_valid remembers whether a capture preceded the freeze
                    if (!freeze) begin
                        w_state_next = r_valid ? ST_LOADED : ST_EMPTY;
                    end else begin
                        w_state_next = ST_FROZEN;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
            if (w_capture) begin
                w_reg_next   = alu_result;
                w_valid_next = 1'b1;
            end else begin
                w_reg_next   = r_reg;
                w_valid_next = r_valid;
            end
        end
    end

    assign reg_out    = r_reg;
    assign valid      = r_valid;
    assign zero       = r_valid & (r_reg == '0);
    assign b_feedback = r_reg[FB_W-1:0];

`ifdef ALU_RESULT_HISTORY_EN
    alu_history_buf #(
        .DEPTH   (HIST_DEPTH),
        .ENTRY_W (DATA_W + 3)
    ) u_hist (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (w_capture),
        .wr_data ({alu_func, alu_result}),
        .rd_sel  (hist_sel),
        .rd_data (hist_data),
        .count   (hist_count)
    );
`else
    logic w_unused;
    assign w_unused   = ^{hist_sel, alu_func, HIST_DEPTH[0]};
    assign hist_data  = '0;
    assign hist_count = 3'd0;
`endif

endmodule

// File: tb/tb_alu_result_register.sv
// Directed plus random stimulus against a queue-based reference model of the result register.
module tb_alu_result_register;

    logic        clock = 1'b0;
    logic        reset, load, clear, freeze;
    logic [7:0]  alu_result;
    logic [2:0]  alu_func;
    logic [1:0]  hist_sel;
    logic [7:0]  reg_out;
    logic [3:0]  b_feedback;
    logic        valid, zero;
    logic [10:0] hist_data;
    logic [2:0]  hist_count;

    int total = 0;
    int bad   = 0;

    // Reference model: last captured value, whether anything is held,
    // whether the previous cycle froze, and newest-first history.
    logic [7:0]  m_reg;
    logic        m_held;
    logic        m_prev_load;
    logic        m_was_frozen;
    logic [10:0] m_hist[$];

    alu_result_register dut (
        .clock(clock), .reset(reset), .alu_result(alu_result), .alu_func(alu_func),
        .load(load), .clear(clear), .freeze(freeze), .reg_out(reg_out),
        .b_feedback(b_feedback), .valid(valid), .zero(zero), .hist_sel(hist_sel),
        .hist_data(hist_data), .hist_count(hist_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, ld, clr, frz, input logic [7:0] res, input logic [2:0] fn);
        if (rst) begin
            m_reg = 8'h00; m_held = 1'b0; m_prev_load = 1'b0; m_was_frozen = 1'b0;
            m_hist.delete();
        end else begin
            if (clr) begin
                m_reg = 8'h00; m_held = 1'b0; m_was_frozen = 1'b0;
                m_hist.delete();
            end else begin
                if (ld && !m_prev_load && !frz && !m_was_frozen) begin
                    m_reg = res; m_held = 1'b1;
                    m_hist.push_front({fn, res});
                    if (m_hist.size() > 4) void'(m_hist.pop_back());
                end
                m_was_frozen = frz;
            end
            m_prev_load = ld;
        end
    endtask

    task automatic check_all(input string tag);
        logic [10:0] exp_hd;
        logic [2:0]  exp_hc;
        exp_hd = 11'd0;
        exp_hc = 3'd0;
`ifdef ALU_RESULT_HISTORY_EN
        exp_hc = 3'(m_hist.size());
        if (int'(hist_sel) < m_hist.size()) exp_hd = m_hist[hist_sel];
`endif
        chk({tag, ".reg_out"}, 32'(reg_out), 32'(m_reg));
        chk({tag, ".b_feedback"}, 32'(b_feedback), 32'(m_reg % 16));
        chk({tag, ".valid"}, 32'(valid), 32'(m_held));
        chk({tag, ".zero"}, 32'(zero), 32'(m_held && m_reg == 8'h00));
        chk({tag, ".hist_count"}, 32'(hist_count), 32'(exp_hc));
        chk({tag, ".hist_data"}, 32'(hist_data), 32'(exp_hd));
    endtask

    task automatic step(input string tag, input logic rst, ld, clr, frz,
                        input logic [7:0] res, input logic [2:0] fn, input logic [1:0] sel);
        @(negedge clock);
        reset = rst; load = ld; clear = clr; freeze = frz;
        alu_result = res; alu_func = fn; hist_sel = sel;
        @(posedge clock);
        model_edge(rst, ld, clr, frz, res, fn);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [10:0] hexp;
        reset = 1'b1; load = 1'b0; clear = 1'b0; freeze = 1'b0;
        alu_result = 8'h00; alu_func = 3'd0; hist_sel = 2'd0;
        m_reg = 8'h00; m_held = 1'b0; m_prev_load = 1'b0; m_was_frozen = 1'b0;

        step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);
        step("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);
        chk("reset.reg_out", 32'(reg_out), 32'h0);
        chk("reset.valid", 32'(valid), 32'h0);

        // Capture and feedback
        step("cap", 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 3'd2, 2'd0);
        chk("cap.reg_out", 32'(reg_out), 32'h3C);
        chk("cap.b_feedback", 32'(b_feedback), 32'hC);
        chk("cap.valid", 32'(valid), 32'h1);
        chk("cap.zero", 32'(zero), 32'h0);
        step("cap_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 3'd2, 2'd0);

        // Held load gives exactly one capture
        for (int i = 1; i <= 5; i++) step("hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 3'd0, 2'd0);
        chk("hold.reg_out", 32'(reg_out), 32'h01);
        step("hold_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);

        // Zero flag on a captured zero
        step("zcap", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);
        chk("zcap.zero", 32'(zero), 32'h1);
        step("zrel", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);

        // Freeze drops loads, including a still-high load at release
        step("f_cap", 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 3'd0, 2'd0);
        step("f_rel", 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 3'd0, 2'd0);
        step("f_rise", 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 3'd0, 2'd0);
        chk("freeze.reg_out", 32'(reg_out), 32'h10);
        step("f_unfrz", 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 3'd0, 2'd0);
        step("f_after", 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 3'd0, 2'd0);
        chk("unfreeze.reg_out", 32'(reg_out), 32'h10);
        chk("unfreeze.valid", 32'(valid), 32'h1);
        step("f_low", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);

        // Clear beats load
        step("clr", 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 3'd0, 2'd0);
        chk("clear.reg_out", 32'(reg_out), 32'h0);
        chk("clear.valid", 32'(valid), 32'h0);
        chk("clear.zero", 32'(zero), 32'h0);
        step("clr_low", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 2'd0);

        // Frozen with nothing captured returns to empty; clear held under freeze
        step("fe0", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 2'd0);
        step("fe1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 3'd0, 2'd0);
        step("fe2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 3'd0, 2'd0);
        chk("frozen_empty.valid", 32'(valid), 32'h0);

        // History wrap
        for (int i = 1; i <= 5; i++) begin
            step("h_ld", 1'b0, 1'b1, 1'b0, 1'b0, 8'(i), 3'd1, 2'd0);
            step("h_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 2'd0);
        end
        hexp = 11'd0;
`ifdef ALU_RESULT_HISTORY_EN
        hexp = {3'd1, 8'h05};
        chk("hist.count", 32'(hist_count), 32'd4);
`endif
        chk("hist.sel0", 32'(hist_data), 32'(hexp));
        step("h_sel3", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 2'd3);
`ifdef ALU_RESULT_HISTORY_EN
        hexp = {3'd1, 8'h02};
`endif
        chk("hist.sel3", 32'(hist_data), 32'(hexp));
        step("h_clr", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 2'd0);
        chk("hist_clr.count", 32'(hist_count), 32'd0);
        chk("hist_clr.data", 32'(hist_data), 32'd0);

        // Reset mid-operation
        step("r_cap", 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd3, 2'd0);
        step("r_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 2'd0);
        chk("pre_reset.reg_out", 32'(reg_out), 32'hA5);
        step("r_mid", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd3, 2'd0);
        chk("mid_reset.reg_out", 32'(reg_out), 32'h0);
        chk("mid_reset.valid", 32'(valid), 32'h0);
        chk("mid_reset.hist_count", 32'(hist_count), 32'h0);
        step("r_hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 3'd3, 2'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 6),
                 1'($urandom_range(0, 99) < 25),
                 8'($urandom), 3'($urandom_range(0, 5)), 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
